// File: rtl/ex_vector_sequencer.sv
// Execute-stage lane sequencer: scalar ops finish in one cycle, vector ops
// sweep 32 lanes LANES_PER_CYCLE at a time while stalling upstream.
module ex_vector_sequencer #(
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ValidIN,
    input  logic          FlushIN,
    input  logic [4:0]    OpCodeIN,
    input  logic [3:0]    CodigoALUIN,
    input  logic          WriteRegIN,
    input  logic [4:0]    DirWriteIN,
    input  logic [31:0]   ValAIN,
    input  logic [31:0]   ValBIN,
    input  logic [1023:0] DIN,
    output logic          StallOUT,
    output logic          DoneOUT,
    output logic          IsVecOUT,
    output logic [31:0]   ScalarResOUT,
    output logic [1023:0] VecResOUT,
    output logic          WriteRegOUT,
    output logic [4:0]    DirWriteOUT
);

    localparam int GROUPS = 32 / LANES_PER_CYCLE;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [GW-1:0]   grp;
    logic [3:0]      code_q;
    logic [31:0]     vala_q;
    logic [1023:0]   d_q;
    logic            accept;
    logic            last;
    logic            unused;

    assign accept = (state != BUSY) && ValidIN && !FlushIN;
    assign last   = (grp == GW'(GROUPS - 1));
    assign unused = ^OpCodeIN[3:0];

    // Shared lane/scalar ALU; y supplies both the second operand and shift amount.
    function automatic logic [31:0] alu(input logic [3:0] op,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
        logic [31:0] r;
        case (op)
            4'd0:    r = x + y;
            4'd1:    r = x - y;
            4'd2:    r = x & y;
            4'd3:    r = x | y;
            4'd4:    r = x ^ y;
            4'd5:    r = x << y[4:0];
            4'd6:    r = x >> y[4:0];
            4'd7:    r = $unsigned($signed(x) >>> y[4:0]);
            4'd8:    r = x * y;
            default: r = x;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grp          <= '0;
            code_q       <= '0;
            vala_q       <= '0;
            d_q          <= '0;
            StallOUT     <= 1'b0;
            DoneOUT      <= 1'b0;
            IsVecOUT     <= 1'b0;
            ScalarResOUT <= '0;
            VecResOUT    <= '0;
            WriteRegOUT  <= 1'b0;
            DirWriteOUT  <= '0;
        end else begin
            DoneOUT <= 1'b0;
            // The current group is written even on a flush edge.
            if (state == BUSY) begin
                for (int j = 0; j < LANES_PER_CYCLE; j++) begin
                    VecResOUT[(int'(grp) * LANES_PER_CYCLE + j) * 32 +: 32] <=
                        alu(code_q,
                            d_q[(int'(grp) * LANES_PER_CYCLE + j) * 32 +: 32],
                            vala_q);
                end
                grp <= grp + GW'(1);
            end
            if (FlushIN) begin
                state    <= IDLE;
                StallOUT <= 1'b0;
            end else if (accept) begin
                grp         <= '0;
                code_q      <= CodigoALUIN;
                vala_q      <= ValAIN;
                d_q         <= DIN;
                IsVecOUT    <= OpCodeIN[4];
                WriteRegOUT <= WriteRegIN;
                DirWriteOUT <= DirWriteIN;
                if (OpCodeIN[4]) begin
                    state    <= BUSY;
                    StallOUT <= 1'b1;
                end else begin
                    state        <= DONE;
                    DoneOUT      <= 1'b1;
                    ScalarResOUT <= alu(CodigoALUIN, ValAIN, ValBIN);
                end
            end else if (state == BUSY) begin
                if (last) begin
                    state    <= DONE;
                    StallOUT <= 1'b0;
                    DoneOUT  <= 1'b1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ex_vector_sequencer.sv
// Directed bench for ex_vector_sequencer: default lane width plus
// LANES_PER_CYCLE=1 and =32 instances sharing the same stimulus.
module tb_ex_vector_sequencer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ValidIN, FlushIN, WriteRegIN;
    logic [4:0]    OpCodeIN, DirWriteIN;
    logic [3:0]    CodigoALUIN;
    logic [31:0]   ValAIN, ValBIN;
    logic [1023:0] DIN;

    logic          stall4, done4, isvec4, wr4;
    logic [4:0]    dir4;
    logic [31:0]   sres4;
    logic [1023:0] vres4;
    logic          stall1, done1, isvec1, wr1;
    logic [4:0]    dir1;
    logic [31:0]   sres1;
    logic [1023:0] vres1;
    logic          stall32, done32, isvec32, wr32;
    logic [4:0]    dir32;
    logic [31:0]   sres32;
    logic [1023:0] vres32;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_vector_sequencer #(.LANES_PER_CYCLE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .ValidIN(ValidIN), .FlushIN(FlushIN),
        .OpCodeIN(OpCodeIN), .CodigoALUIN(CodigoALUIN),
        .WriteRegIN(WriteRegIN), .DirWriteIN(DirWriteIN),
        .ValAIN(ValAIN), .ValBIN(ValBIN), .DIN(DIN),
        .StallOUT(stall4), .DoneOUT(done4), .IsVecOUT(isvec4),
        .ScalarResOUT(sres4), .VecResOUT(vres4),
        .WriteRegOUT(wr4), .DirWriteOUT(dir4));

    ex_vector_sequencer #(.LANES_PER_CYCLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .ValidIN(ValidIN), .FlushIN(FlushIN),
        .OpCodeIN(OpCodeIN), .CodigoALUIN(CodigoALUIN),
        .WriteRegIN(WriteRegIN), .DirWriteIN(DirWriteIN),
        .ValAIN(ValAIN), .ValBIN(ValBIN), .DIN(DIN),
        .StallOUT(stall1), .DoneOUT(done1), .IsVecOUT(isvec1),
        .ScalarResOUT(sres1), .VecResOUT(vres1),
        .WriteRegOUT(wr1), .DirWriteOUT(dir1));

    ex_vector_sequencer #(.LANES_PER_CYCLE(32)) u32 (
        .clk(clk), .rst_n(rst_n), .ValidIN(ValidIN), .FlushIN(FlushIN),
        .OpCodeIN(OpCodeIN), .CodigoALUIN(CodigoALUIN),
        .WriteRegIN(WriteRegIN), .DirWriteIN(DirWriteIN),
        .ValAIN(ValAIN), .ValBIN(ValBIN), .DIN(DIN),
        .StallOUT(stall32), .DoneOUT(done32), .IsVecOUT(isvec32),
        .ScalarResOUT(sres32), .VecResOUT(vres32),
        .WriteRegOUT(wr32), .DirWriteOUT(dir32));

    function automatic logic [31:0] lane(input logic [1023:0] v, input int i);
        return v[32*i +: 32];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] opc, input logic [3:0] code,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1023:0] d);
        ValidIN     = 1'b1;
        OpCodeIN    = opc;
        CodigoALUIN = code;
        ValAIN      = a;
        ValBIN      = b;
        DIN         = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ValidIN = 0; FlushIN = 0; WriteRegIN = 0;
        OpCodeIN = '0; DirWriteIN = '0; CodigoALUIN = '0;
        ValAIN = '0; ValBIN = '0; DIN = '0;
        #12;
        n_cmp++; if (stall4 !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", stall4); end
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done4); end
        n_cmp++; if (isvec4 !== 1'b0) begin n_bad++; $display("FAIL reset_isvec got=%b want=0", isvec4); end
        n_cmp++; if (wr4 !== 1'b0 || dir4 !== 5'd0) begin n_bad++; $display("FAIL reset_wr_dir got=%b/%0d want=0/0", wr4, dir4); end
        n_cmp++; if (sres4 !== 32'd0) begin n_bad++; $display("FAIL reset_sres got=%h want=0", sres4); end
        n_cmp++; if (vres4 !== 1024'd0) begin n_bad++; $display("FAIL reset_vres got nonzero want=0"); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scalar;
        drive(5'h00, 4'd0, 32'd5, 32'd7, '0);
        WriteRegIN = 1'b1; DirWriteIN = 5'd3;
        tick();
        ValidIN = 1'b0; WriteRegIN = 1'b0; DirWriteIN = 5'd0;
        n_cmp++; if (done4 !== 1'b1) begin n_bad++; $display("FAIL scalar_done got=%b want=1", done4); end
        n_cmp++; if (sres4 !== 32'd12) begin n_bad++; $display("FAIL scalar_add got=%0d want=12", sres4); end
        n_cmp++; if (isvec4 !== 1'b0 || stall4 !== 1'b0) begin n_bad++; $display("FAIL scalar_flags got=%b%b want=00", isvec4, stall4); end
        n_cmp++; if (wr4 !== 1'b1 || dir4 !== 5'd3) begin n_bad++; $display("FAIL scalar_wr_dir got=%b/%0d want=1/3", wr4, dir4); end
        tick();
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL scalar_done_pulse got=%b want=0", done4); end
        n_cmp++; if (wr4 !== 1'b1 || dir4 !== 5'd3) begin n_bad++; $display("FAIL scalar_wr_hold got=%b/%0d want=1/3", wr4, dir4); end
    endtask

    task automatic test_scalar_ops;
        logic [3:0]  codes [6] = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd8, 4'd12};
        logic [31:0] as    [6] = '{32'd5, 32'hF0F0, 32'hF0F0, 32'h10000, 32'd7, 32'hABCD};
        logic [31:0] bs    [6] = '{32'd7, 32'hFF00, 32'h0F00, 32'h10000, 32'd6, 32'h1234};
        logic [31:0] exps  [6] = '{32'hFFFFFFFE, 32'hF000, 32'hFFF0, 32'd0, 32'd42, 32'hABCD};
        for (int k = 0; k < 6; k++) begin
            drive(5'h00, codes[k], as[k], bs[k], '0);
            tick();
            n_cmp++;
            if (done4 !== 1'b1 || sres4 !== exps[k]) begin
                n_bad++;
                $display("FAIL scalar_op%0d got done=%b res=%h want done=1 res=%h", k, done4, sres4, exps[k]);
            end
        end
        ValidIN = 1'b0;
        tick();
    endtask

    task automatic test_vector_sll;
        logic [1023:0] d;
        int stalls = 0, done_at = 0, bad = 0;
        for (int i = 0; i < 32; i++) d[32*i +: 32] = i;
        drive(5'h10, 4'd5, 32'd4, 32'd0, d);
        tick();
        ValidIN = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (stall4) stalls++;
            if (done4) begin done_at = c; break; end
            tick();
        end
        n_cmp++; if (stalls != 8) begin n_bad++; $display("FAIL vsll_stalls got=%0d want=8", stalls); end
        n_cmp++; if (done_at != 9) begin n_bad++; $display("FAIL vsll_done_cycle got=%0d want=9", done_at); end
        n_cmp++; if (isvec4 !== 1'b1) begin n_bad++; $display("FAIL vsll_isvec got=%b want=1", isvec4); end
        for (int i = 0; i < 32; i++) if (lane(vres4, i) !== 32'(16 * i)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL vsll_lanes got=%0d bad lanes want=0", bad); end
        n_cmp++; if (lane(vres4, 31) !== 32'd496) begin n_bad++; $display("FAIL vsll_lane31 got=%0d want=496", lane(vres4, 31)); end
        tick();
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL vsll_done_pulse got=%b want=0", done4); end
    endtask

    task automatic test_back_to_back;
        logic [1023:0] d;
        int done_at = 0;
        for (int i = 0; i < 32; i++) d[32*i +: 32] = i;
        drive(5'h10, 4'd0, 32'd100, 32'd0, d);
        tick();
        drive(5'h00, 4'd4, 32'hFF00FF00, 32'h0F0F0F0F, '0);
        for (int c = 1; c <= 40; c++) begin
            if (done4) begin done_at = c; break; end
            tick();
        end
        n_cmp++; if (done_at != 9 || isvec4 !== 1'b1) begin n_bad++; $display("FAIL b2b_vec_done got=%0d/%b want=9/1", done_at, isvec4); end
        n_cmp++; if (lane(vres4, 5) !== 32'd105) begin n_bad++; $display("FAIL b2b_vec_lane5 got=%0d want=105", lane(vres4, 5)); end
        tick();
        ValidIN = 1'b0;
        n_cmp++; if (done4 !== 1'b1 || isvec4 !== 1'b0) begin n_bad++; $display("FAIL b2b_scalar_done got=%b/%b want=1/0", done4, isvec4); end
        n_cmp++; if (sres4 !== 32'hF00FF00F) begin n_bad++; $display("FAIL b2b_xor got=%h want=f00ff00f", sres4); end
        n_cmp++; if (stall4 !== 1'b0 || lane(vres4, 5) !== 32'd105) begin n_bad++; $display("FAIL b2b_vec_kept got stall=%b lane5=%0d want 0/105", stall4, lane(vres4, 5)); end
        tick();
    endtask

    task automatic test_flush;
        logic [1023:0] d;
        int bad = 0, dones = 0;
        logic [31:0] want;
        for (int i = 0; i < 32; i++) d[32*i +: 32] = i;
        drive(5'h10, 4'd3, 32'h1000, 32'd0, d);
        tick();
        ValidIN = 1'b0;
        tick();
        tick();
        n_cmp++; if (stall4 !== 1'b1) begin n_bad++; $display("FAIL flush_busy3 got=%b want=1", stall4); end
        FlushIN = 1'b1;
        tick();
        FlushIN = 1'b0;
        n_cmp++; if (stall4 !== 1'b0 || done4 !== 1'b0) begin n_bad++; $display("FAIL flush_state got=%b/%b want=0/0", stall4, done4); end
        for (int c = 0; c < 12; c++) begin
            if (done4) dones++;
            tick();
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL flush_no_done got=%0d want=0", dones); end
        for (int i = 0; i < 32; i++) begin
            want = (i < 12) ? (32'h1000 | 32'(i)) : 32'(i + 100);
            if (lane(vres4, i) !== want) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL flush_partial got=%0d bad lanes want=0", bad); end
    endtask

    task automatic test_flush_valid;
        FlushIN = 1'b1;
        drive(5'h00, 4'd0, 32'd1, 32'd1, '0);
        tick();
        ValidIN = 1'b0; FlushIN = 1'b0;
        n_cmp++; if (done4 !== 1'b0 || stall4 !== 1'b0) begin n_bad++; $display("FAIL flushv_accept got=%b/%b want=0/0", done4, stall4); end
        n_cmp++; if (sres4 !== 32'hF00FF00F) begin n_bad++; $display("FAIL flushv_sres got=%h want=f00ff00f", sres4); end
        tick();
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL flushv_idle got=%b want=0", done4); end
    endtask

    task automatic test_arith;
        logic [1023:0] d;
        int done_at, bad;
        logic [31:0] want;
        // ADD wrap-around
        d = '1; done_at = 0; bad = 0;
        drive(5'h10, 4'd0, 32'd1, 32'd0, d);
        tick(); ValidIN = 1'b0;
        for (int c = 1; c <= 40; c++) begin if (done4) begin done_at = c; break; end tick(); end
        for (int i = 0; i < 32; i++) if (lane(vres4, i) !== 32'd0) bad++;
        n_cmp++; if (done_at != 9 || bad != 0) begin n_bad++; $display("FAIL arith_add_wrap got done=%0d bad=%0d want 9/0", done_at, bad); end
        tick();
        // MUL low half
        for (int i = 0; i < 32; i++) d[32*i +: 32] = 32'h10000;
        d[63:32] = 32'd3; done_at = 0;
        drive(5'h10, 4'd8, 32'h10000, 32'd0, d);
        tick(); ValidIN = 1'b0;
        for (int c = 1; c <= 40; c++) begin if (done4) begin done_at = c; break; end tick(); end
        n_cmp++; if (done_at != 9 || lane(vres4, 0) !== 32'd0) begin n_bad++; $display("FAIL arith_mul got done=%0d lane0=%h want 9/0", done_at, lane(vres4, 0)); end
        n_cmp++; if (lane(vres4, 1) !== 32'h30000) begin n_bad++; $display("FAIL arith_mul_lane1 got=%h want=30000", lane(vres4, 1)); end
        tick();
        // SRA sign fill
        for (int i = 0; i < 32; i++) d[32*i +: 32] = 32'h80000000 | 32'(i);
        done_at = 0; bad = 0;
        drive(5'h10, 4'd7, 32'd4, 32'd0, d);
        tick(); ValidIN = 1'b0;
        for (int c = 1; c <= 40; c++) begin if (done4) begin done_at = c; break; end tick(); end
        for (int i = 0; i < 32; i++) begin
            want = (i >= 16) ? 32'hF8000001 : 32'hF8000000;
            if (lane(vres4, i) !== want) bad++;
        end
        n_cmp++; if (done_at != 9 || bad != 0) begin n_bad++; $display("FAIL arith_sra got done=%0d bad=%0d want 9/0", done_at, bad); end
        tick();
    endtask

    task automatic test_reset_busy;
        int dones = 0;
        drive(5'h10, 4'd0, 32'd1, 32'd0, '0);
        tick();
        ValidIN = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (stall4 !== 1'b0 || done4 !== 1'b0 || vres4 !== 1024'd0) begin n_bad++; $display("FAIL rstbusy_clear got stall=%b done=%b", stall4, done4); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done4) dones++;
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rstbusy_no_done got=%0d want=0", dones); end
    endtask

    task automatic test_sweep;
        logic [1023:0] d;
        int s1 = 0, s32 = 0, d1 = 0, d32 = 0, bad = 0;
        for (int i = 0; i < 32; i++) d[32*i +: 32] = i;
        drive(5'h10, 4'd5, 32'd4, 32'd0, d);
        tick();
        ValidIN = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (stall1) s1++;
            if (stall32) s32++;
            if (done1 && d1 == 0) d1 = c;
            if (done32 && d32 == 0) d32 = c;
            if (d1 != 0 && d32 != 0) break;
            tick();
        end
        n_cmp++; if (s1 != 32 || d1 != 33) begin n_bad++; $display("FAIL sweep_l1 got stalls=%0d done=%0d want 32/33", s1, d1); end
        n_cmp++; if (s32 != 1 || d32 != 2) begin n_bad++; $display("FAIL sweep_l32 got stalls=%0d done=%0d want 1/2", s32, d32); end
        for (int i = 0; i < 32; i++) begin
            if (lane(vres1, i) !== 32'(16 * i)) bad++;
            if (lane(vres32, i) !== 32'(16 * i)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL sweep_lanes got=%0d bad lanes want=0", bad); end
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_scalar_ops();
        test_vector_sll();
        test_back_to_back();
        test_flush();
        test_flush_valid();
        test_arith();
        test_reset_busy();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
